if_id_skid_stage: RTL and testbench

Parametrised IF/ID pipeline stage with a valid/ready handshake, a two-entry skid buffer, synchronous flush and NOP bubble insertion. It sits between the fetch unit and the decoder. It replaces the plain always-loading IF/ID register, so fetch can run while decode stalls, and taken branches can squash in-flight instructions. Its ready output is registered: out_ready has no combinational path to in_ready.

---
 rtl/if_id_skid_stage.sv | 116 +++++++++++
 tb/tb_if_id_skid_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a two-entry skid buffer,
// synchronous flush and NOP presentation when no instruction is held.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | nothing held, out_valid low, out_ins = NOP_INS
// ONE   | main register holds the head instruction
// FULL  | main holds the head, skid holds the next one
module if_id_skid_stage #(
    parameter int unsigned          PC_W    = 16,
    parameter int unsigned          INS_W   = 16,
    parameter logic [INS_W-1:0]     NOP_INS = {INS_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [INS_W-1:0] in_ins,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_ins,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INS_W-1:0]   main_ins_q, main_ins_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INS_W-1:0]   skid_ins_q, skid_ins_d;
    logic               in_fire;
    logic               out_fire;

    // in_ready comes from the state register only, so out_ready never reaches it.
    assign in_ready  = (state_q != FULL) & reset_n;
    assign out_valid = (state_q != EMPTY);
    assign out_ins   = out_valid ? main_ins_q : NOP_INS;
    assign out_pc    = main_pc_q;
    assign occupancy = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_pc_d  = main_pc_q;
        main_ins_d = main_ins_q;
        skid_pc_d  = skid_pc_q;
        skid_ins_d = skid_ins_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d    = ONE;
                    main_pc_d  = in_pc;
                    main_ins_d = in_ins;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_pc_d  = in_pc;
                    main_ins_d = in_ins;
                end else if (in_fire) begin
                    state_d    = FULL;
                    skid_pc_d  = in_pc;
                    skid_ins_d = in_ins;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d    = ONE;
                    main_pc_d  = skid_pc_q;
                    main_ins_d = skid_ins_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush only drops validity; payload registers keep their contents so
        // out_pc keeps showing the last head PC.
        if (flush) begin
            state_d    = EMPTY;
            main_pc_d  = main_pc_q;
            main_ins_d = main_ins_q;
            skid_pc_d  = skid_pc_q;
            skid_ins_d = skid_ins_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            main_pc_q  <= '0;
            main_ins_q <= '0;
            skid_pc_q  <= '0;
            skid_ins_q <= '0;
        end else begin
            state_q    <= state_d;
            main_pc_q  <= main_pc_d;
            main_ins_q <= main_ins_d;
            skid_pc_q  <= skid_pc_d;
            skid_ins_q <= skid_ins_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed vector table, hand-written corner sequences and a random
// scoreboard run for the IF/ID skid stage.
module tb_if_id_skid_stage;

    localparam int unsigned   PC_W  = 32;
    localparam int unsigned   INS_W = 32;
    localparam logic [31:0]   NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_ins;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    if_id_skid_stage #(
        .PC_W    (PC_W),
        .INS_W   (INS_W),
        .NOP_INS (NOP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_ins    (in_ins),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ins   (out_ins),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic        ordy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eins;
        logic [1:0]  eocc;
        logic        eir;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;

    vec_t  vecs[15];
    item_t sb[$];

    function automatic vec_t mk(logic iv, logic [31:0] pc, logic [31:0] ins, logic fl,
                                logic ordy, logic ev, logic [31:0] epc, logic [31:0] eins,
                                logic [1:0] eocc, logic eir);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ins = ins; v.fl = fl; v.ordy = ordy;
        v.ev = ev; v.epc = epc; v.eins = eins; v.eocc = eocc; v.eir = eir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] eins, input logic [1:0] eocc, input logic eir);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_pc"},    out_pc,         epc);
        chk({tag, ".out_ins"},   out_ins,        eins);
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(eocc));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(eir));
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_ins    = ins;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        prev_stall;
        logic        m_ir, m_ov;
        logic [31:0] seq;

        // Streaming at full rate
        vecs[0]  = mk(1, 32'h0000, 32'h1111, 0, 1,  1, 32'h0000, 32'h1111, 2'd1, 1);
        vecs[1]  = mk(1, 32'h0002, 32'h2222, 0, 1,  1, 32'h0002, 32'h2222, 2'd1, 1);
        vecs[2]  = mk(1, 32'h0004, 32'h3333, 0, 1,  1, 32'h0004, 32'h3333, 2'd1, 1);
        vecs[3]  = mk(0, 32'h0000, 32'h0000, 0, 1,  0, 32'h0004, NOP,      2'd0, 1);
        // Stall fills the skid entry, then drain in order
        vecs[4]  = mk(1, 32'h0010, 32'hAAAA, 0, 0,  1, 32'h0010, 32'hAAAA, 2'd1, 1);
        vecs[5]  = mk(1, 32'h0012, 32'hBBBB, 0, 0,  1, 32'h0010, 32'hAAAA, 2'd2, 0);
        vecs[6]  = mk(1, 32'h0014, 32'hEEEE, 0, 0,  1, 32'h0010, 32'hAAAA, 2'd2, 0);
        vecs[7]  = mk(0, 32'h0000, 32'h0000, 0, 1,  1, 32'h0012, 32'hBBBB, 2'd1, 1);
        vecs[8]  = mk(0, 32'h0000, 32'h0000, 0, 1,  0, 32'h0012, NOP,      2'd0, 1);
        // Flush while FULL with an instruction offered
        vecs[9]  = mk(1, 32'h0020, 32'h0C0C, 0, 0,  1, 32'h0020, 32'h0C0C, 2'd1, 1);
        vecs[10] = mk(1, 32'h0022, 32'h0C1C, 0, 0,  1, 32'h0020, 32'h0C0C, 2'd2, 0);
        vecs[11] = mk(1, 32'h0024, 32'hCCCC, 1, 0,  0, 32'h0020, NOP,      2'd0, 1);
        // Flush while ONE discards a simultaneous accept
        vecs[12] = mk(1, 32'h0030, 32'h0D0D, 0, 0,  1, 32'h0030, 32'h0D0D, 2'd1, 1);
        vecs[13] = mk(1, 32'h0032, 32'hCCCC, 1, 0,  0, 32'h0030, NOP,      2'd0, 1);
        vecs[14] = mk(0, 32'h0000, 32'h0000, 0, 1,  0, 32'h0030, NOP,      2'd0, 1);

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #2;
        chk_all("reset", 0, 32'h0, NOP, 2'd0, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("release.in_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].fl, vecs[i].ordy);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eins,
                    vecs[i].eocc, vecs[i].eir);
        end

        // Flush coincides with delivery of 0xDDDD: decoder still takes it
        drive(1, 32'h0050, 32'hDDDD, 0, 0);
        tick();
        drive(0, 32'h0, 32'h0, 1, 1);
        #1;
        chk("flushfire.pre_valid", 32'(out_valid), 32'h1);
        chk("flushfire.pre_ins",   out_ins,         32'hDDDD);
        tick();
        chk_all("flushfire.post", 0, 32'h0050, NOP, 2'd0, 1);

        // Async reset in the middle of a FULL stall
        drive(1, 32'h0060, 32'h6060, 0, 0);
        tick();
        drive(1, 32'h0062, 32'h6262, 0, 0);
        tick();
        chk("rststall.occ", 32'(occupancy), 32'h2);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all("rststall.async", 0, 32'h0, NOP, 2'd0, 0);
        drive(0, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #2;
        chk_all("rststall.held", 0, 32'h0, NOP, 2'd0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_all("rststall.release", 0, 32'h0, NOP, 2'd0, 1);
        drive(1, 32'h0070, 32'h7070, 0, 0);
        tick();
        chk_all("rststall.first", 1, 32'h0070, 32'h7070, 2'd1, 1);
        drive(0, 32'h0, 32'h0, 0, 1);
        tick();
        chk_all("rststall.drain", 0, 32'h0070, NOP, 2'd0, 1);

        // Random traffic against a queue model
        sb.delete();
        prev_stall = 1'b0;
        seq = 32'h0000_1000;
        for (int c = 0; c < 10000; c++) begin
            if (!prev_stall) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_pc    = seq;
                in_ins   = seq ^ 32'h5A5A_0000;
                seq      = seq + 1;
            end
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            m_ir = (sb.size() < 2);
            m_ov = (sb.size() > 0);
            chk("rnd.in_ready",  32'(in_ready),  32'(m_ir));
            chk("rnd.out_valid", 32'(out_valid), 32'(m_ov));
            chk("rnd.occupancy", 32'(occupancy), 32'(sb.size()));
            if (m_ov) begin
                chk("rnd.out_ins", out_ins, sb[0].ins);
                chk("rnd.out_pc",  out_pc,  sb[0].pc);
            end else begin
                chk("rnd.nop", out_ins, NOP);
            end
            if (m_ov && out_ready)
                void'(sb.pop_front());
            if (flush)
                sb.delete();
            else if (in_valid && m_ir)
                sb.push_back('{pc: in_pc, ins: in_ins});
            prev_stall = in_valid && !m_ir;
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
